// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Two-phase (FETCH/EXEC) instruction fetch with next-PC select and
//            halt. Optional macro MISALIGN_TRAP_EN traps misaligned targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [6:0]  Opcode,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        take_branch,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic        Halt,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   output logic        halted,
   output logic        misaligned
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      EXEC   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        halted_q;
   logic        misaligned_q;

   logic [31:0] pc_sel;
   logic [31:0] pc_d;
   logic        trap_d;

   always_comb begin
      pc_sel = pc_q + 32'd4;
      if (JumpReg) begin
         pc_sel = {jalr_target[31:1], 1'b0};
      end else if (Jump || take_branch) begin
         pc_sel = branch_target;
      end
   end

`ifdef MISALIGN_TRAP_EN
   assign pc_d   = pc_sel;
   assign trap_d = (pc_sel[1:0] != 2'b00);
`else
   // Silently realign; fetch never stops on a bad target in this build.
   assign pc_d   = pc_sel & 32'hFFFF_FFFC;
   assign trap_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         instr_q      <= NOP;
         halted_q     <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (Halt) begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end else if (trap_d) begin
                  state_q      <= HALTED;
                  halted_q     <= 1'b1;
                  misaligned_q <= 1'b1;
               end else begin
                  pc_q    <= pc_d;
                  state_q <= FETCH;
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   // Redirects are never acted on during reset, so decode must not see valid.
   assign instr_valid = (state_q == EXEC) && !rst;
   assign instr       = instr_q;
   assign Opcode      = instr_q[6:0];
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign halted      = halted_q;
   assign misaligned  = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch (MISALIGN_TRAP_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [6:0]  Opcode;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        take_branch, Jump, JumpReg, Halt;
   logic [31:0] branch_target, jalr_target;
   logic        halted, misaligned;

   int checks   = 0;
   int failures = 0;

   instr_fetch #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .Opcode(Opcode), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4),
      .take_branch(take_branch), .Jump(Jump), .JumpReg(JumpReg), .Halt(Halt),
      .branch_target(branch_target), .jalr_target(jalr_target),
      .halted(halted), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_ctl();
      take_branch = 1'b0;
      Jump        = 1'b0;
      JumpReg     = 1'b0;
      Halt        = 1'b0;
   endtask

   // Called at a FETCH negedge; returns at the following EXEC negedge.
   task automatic fetch_one(input logic [31:0] w);
      imem_ack   = 1'b1;
      imem_rdata = w;
      tick();
      imem_ack   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
      branch_target = 32'h0; jalr_target = 32'h0;
      clear_ctl();
      tick(); tick();
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
      checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      checks++; if (halted !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", halted, misaligned); end
      checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=00000004", pc_plus4); end
      checks++; if (Opcode !== 7'h13) begin failures++; $display("FAIL reset_opcode got=%h exp=13", Opcode); end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [3];
      words[0] = 32'h0050_0093; words[1] = 32'h0020_81B3; words[2] = 32'hFE00_0EE3;
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin failures++; $display("FAIL b2b_fetch_addr[%0d] got=%h req=%b exp=%h", i, imem_addr, imem_req, 4 * i); end
         fetch_one(words[i]);
         checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL b2b_exec[%0d] valid=%b req=%b exp valid=1 req=0", i, instr_valid, imem_req); end
         checks++; if (instr !== words[i] || Opcode !== words[i][6:0]) begin failures++; $display("FAIL b2b_instr[%0d] got=%h op=%h exp=%h", i, instr, Opcode, words[i]); end
         checks++; if (pc !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h/%h exp=%h", i, pc, pc_plus4, 4 * i); end
         tick();
         checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop[%0d] got=%b exp=0", i, instr_valid); end
      end
   endtask

   task automatic test_ack_delay();
      imem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         imem_rdata    = 32'hDEAD_0000 + 32'(k);
         take_branch   = 1'b1;
         branch_target = 32'h0000_0200;
         tick();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0) begin failures++; $display("FAIL delay_wait[%0d] req=%b addr=%h valid=%b exp req=1 addr=c valid=0", k, imem_req, imem_addr, instr_valid); end
         checks++; if (instr !== 32'hFE00_0EE3) begin failures++; $display("FAIL delay_instr_hold[%0d] got=%h exp=fe000ee3", k, instr); end
      end
      clear_ctl();
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL delay_req4 got=%b exp=1", imem_req); end
      fetch_one(32'h00C0_0113);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h00C0_0113) begin failures++; $display("FAIL delay_exec valid=%b instr=%h exp 1/00c00113", instr_valid, instr); end
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
      tick();
      imem_ack = 1'b0;
      checks++; if (imem_addr !== 32'h10 || instr !== 32'h00C0_0113) begin failures++; $display("FAIL ack_in_exec addr=%h instr=%h exp 10/00c00113", imem_addr, instr); end
   endtask

   task automatic test_branch();
      fetch_one(32'h0000_0063);
      take_branch = 1'b1; branch_target = 32'h40;
      tick(); clear_ctl();
      checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL branch_taken got=%h exp=00000040", imem_addr); end
      fetch_one(32'h0000_0067);
      JumpReg = 1'b1; jalr_target = 32'h81; take_branch = 1'b1; branch_target = 32'h300;
      tick(); clear_ctl();
      checks++; if (imem_addr !== 32'h80) begin failures++; $display("FAIL jalr_priority got=%h exp=00000080", imem_addr); end
      fetch_one(32'h0000_006F);
      Jump = 1'b1; branch_target = 32'h120;
      tick(); clear_ctl();
      checks++; if (imem_addr !== 32'h120 || pc_plus4 !== 32'h124) begin failures++; $display("FAIL jump got=%h/%h exp=120/124", imem_addr, pc_plus4); end
   endtask

   task automatic test_wrap();
      fetch_one(32'h0000_006F);
      Jump = 1'b1; branch_target = 32'hFFFF_FFFC;
      tick(); clear_ctl();
      checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/0", imem_addr, pc_plus4); end
      fetch_one(32'h0000_0013);
      tick();
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_seq got=%h exp=00000000", imem_addr); end
   endtask

   task automatic test_halt();
      fetch_one(32'h0000_0013);
      tick();
      fetch_one(32'h0000_0073);
      Halt = 1'b1; JumpReg = 1'b1; jalr_target = 32'h500;
      tick(); clear_ctl();
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h4) begin failures++; $display("FAIL halt_enter h=%b req=%b v=%b pc=%h exp 1/0/0/4", halted, imem_req, instr_valid, pc); end
      for (int k = 0; k < 20; k++) begin
         imem_ack = 1'b1; take_branch = 1'b1; branch_target = 32'h600;
         tick();
         checks++; if (imem_req !== 1'b0 || pc !== 32'h4 || halted !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL halt_hold[%0d] req=%b pc=%h h=%b v=%b", k, imem_req, pc, halted, instr_valid); end
      end
      clear_ctl(); imem_ack = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin failures++; $display("FAIL halt_exit h=%b req=%b addr=%h exp 0/1/%h", halted, imem_req, imem_addr, RST_PC); end
   endtask

   task automatic test_reset_override();
      fetch_one(32'h0000_0013);
      tick();
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      tick();
      rst = 1'b0; imem_ack = 1'b0;
      checks++; if (instr !== 32'h0000_0013 || imem_addr !== RST_PC || imem_req !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL rst_vs_ack instr=%h addr=%h req=%b v=%b", instr, imem_addr, imem_req, instr_valid); end
      fetch_one(32'h0050_0093);
      Halt = 1'b1; JumpReg = 1'b1; jalr_target = 32'h700; rst = 1'b1;
      #1;
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
      tick();
      rst = 1'b0; clear_ctl();
      checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC || instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_vs_halt h=%b req=%b addr=%h instr=%h", halted, imem_req, imem_addr, instr); end
   endtask

   task automatic test_misalign();
      fetch_one(32'h0000_006F);
      Jump = 1'b1; branch_target = 32'h42;
      tick(); clear_ctl();
`ifdef MISALIGN_TRAP_EN
      checks++; if (misaligned !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL misalign_trap m=%b h=%b req=%b exp 1/1/0", misaligned, halted, imem_req); end
`else
      checks++; if (imem_addr !== 32'h40 || misaligned !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL misalign_align addr=%h m=%b h=%b exp 40/0/0", imem_addr, misaligned, halted); end
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_ack_delay();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_override();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: imem_req  output  1  instruction memory read request.
REQ-005 SHALL have port: imem_addr  output  32  byte address of requested word (equals pc).
REQ-006 SHALL have port: imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  instruction word from memory.
REQ-008 SHALL have port: instr  output  32  latched instruction for decode.
REQ-009 SHALL have port: Opcode  output  7  instr[6:0], drives the decoder's Opcode input.
REQ-010 SHALL have port: instr_valid  output  1  instr is current and redirect inputs are sampled this cycle.
REQ-011 SHALL have port: pc  output  32  address of the current instruction.
REQ-012 SHALL have port: pc_plus4  output  32  pc + 4, link value for jal/jalr.
REQ-013 SHALL have ports: take_branch, Jump, JumpReg, Halt  input  1 each  redirect/stop controls from decode and ALU.
REQ-014 SHALL have ports: branch_target, jalr_target  input  32 each  pc+imm and rs1+imm targets.
REQ-015 SHALL have ports: halted, misaligned  output  1 each  status flags.

Function
REQ-016 SHALL implement states FETCH, EXEC, HALTED.
REQ-017 FETCH: imem_req=1, imem_addr=pc held stable; on imem_ack latch imem_rdata into instr, go EXEC; otherwise remain.
REQ-018 EXEC: instr_valid=1, imem_req=0; exactly one cycle; at clock edge update pc and go FETCH, or go HALTED.
REQ-019 Next-PC priority in EXEC: Halt (pc held, go HALTED) > JumpReg ({jalr_target[31:1],1'b0}) > Jump (branch_target) > take_branch (branch_target) > pc+4.
REQ-020 Redirect inputs SHALL be ignored outside EXEC; imem_ack SHALL be ignored outside FETCH.
REQ-021 Latency: instr_valid asserts the cycle after imem_ack; minimum 2 cycles per instruction (ack in first FETCH cycle).
REQ-022 HALTED: imem_req=0, instr_valid=0, halted=1, pc frozen; exited only by rst.
REQ-023 pc arithmetic SHALL be 32-bit modulo; pc 32'hFFFF_FFFC + 4 wraps to 0.
REQ-024 Opcode and pc_plus4 SHALL be combinational from instr and pc.

Reset
REQ-025 rst SHALL set pc=RESET_PC, state=FETCH, instr=32'h0000_0013 (nop), halted=0, misaligned=0.
REQ-026 During the rst cycle instr_valid=0 and imem_ack/imem_rdata SHALL be ignored; an outstanding fetch is abandoned and reissued at RESET_PC the next cycle.
REQ-027 rst SHALL override Halt and any redirect in the same cycle.

Configuration
REQ-028 Macro MISALIGN_TRAP_EN defined: a selected next pc with [1:0]!=2'b00 SHALL not be loaded; instead go HALTED with misaligned=1, halted=1.
REQ-029 MISALIGN_TRAP_EN undefined: next pc[1:0] forced to 2'b00 and fetch continues; misaligned tied 0.

Verification
REQ-030 Reset, memory acks every FETCH cycle -> imem_addr 0x0, then 0x4 two cycles later; instr_valid pulses every other cycle.
REQ-031 imem_ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable, instr_valid exactly one cycle after ack.
REQ-032 EXEC with take_branch=1, branch_target=0x40 -> next imem_addr 0x40; JumpReg=1, jalr_target=0x81 with take_branch=1 simultaneously -> 0x80.
REQ-033 Halt=1 in EXEC -> halted=1 next cycle, imem_req 0 for 20 cycles, pc unchanged; rst pulse -> fetch resumes at RESET_PC.
REQ-034 rst asserted in FETCH coincident with imem_ack, imem_rdata=0x00500093 -> instr stays 0x00000013, next imem_addr RESET_PC.
REQ-035 Jump=1, branch_target=0x42 -> with MISALIGN_TRAP_EN misaligned=1, halted=1; without it next imem_addr 0x40.
